// File: rtl/fp_divider.sv
// fp_divider: a_in / b_in by radix-2 restoring mantissa division, one quotient bit per clock.
// Optional FP_DIV_STICKY_EN selects round-to-nearest-even; otherwise it rounds half-up on the guard bit.
// Latency: M+5 cycles for normal operands and 1 cycle for zero operands. A start while busy is ignored.
module fp_divider #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                start_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   b_in,
  output logic                                busy_out,
  output logic                                done_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   fpd_out,
  output logic                                overflow_out,
  output logic                                underflow_out,
  output logic                                div_by_zero_out
);
  localparam int M    = MANTISSA_WIDTH;
  localparam int E    = EXP_WIDTH;
  localparam int W    = E + M + 1;
  localparam int EW   = E + 2;
  localparam int BIAS = 2 ** (E - 1) - 1;
  localparam int CW   = $clog2(M + 3);
  localparam logic [EW-1:0] E_MAX = EW'(2 ** E - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORMALIZE, DONE} state_t;
  state_t state_q, state_d;

  logic          sign_q;
  logic [EW-1:0] e_q;
  logic [M+1:0]  rem_q;
  logic [M:0]    dvsr_q;
  logic [M+2:0]  q_q;
  logic [CW-1:0] cnt_q;

  logic a_zero, b_zero, special, accept;
  assign a_zero  = (a_in[W-2:0] == '0);
  assign b_zero  = (b_in[W-2:0] == '0);
  assign special = a_zero | b_zero;

  always_comb begin
    state_d  = state_q;
    busy_out = 1'b0;
    done_out = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done_out = (state_q == DONE);
        state_d  = IDLE;
        if (start_in) begin
          accept  = 1'b1;
          state_d = special ? DONE : DIVIDE;
        end
      end
      DIVIDE: begin
        busy_out = 1'b1;
        if (cnt_q == CW'(M + 2)) state_d = NORMALIZE;
      end
      NORMALIZE: begin
        busy_out = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Compare-then-shift keeps the partial remainder below 2*divisor, so M+2 bits suffice.
  logic [M+2:0] trial;
  logic         q_bit;
  logic [M+1:0] rem_keep, rem_nxt;
  assign trial    = {1'b0, rem_q} - {2'b00, dvsr_q};
  assign q_bit    = ~trial[M+2];
  assign rem_keep = q_bit ? trial[M+1:0] : rem_q;
  assign rem_nxt  = {rem_keep[M:0], 1'b0};

  logic [M-1:0]  frac_n, frac_r;
  logic [M:0]    frac_sum;
  logic          guard, round_up, ovf, unf;
  logic [EW-1:0] e_n, e_r;
`ifdef FP_DIV_STICKY_EN
  logic          sticky;
`endif

  always_comb begin
    frac_n = q_q[M:1];
    guard  = q_q[0];
    e_n    = e_q - EW'(1);
`ifdef FP_DIV_STICKY_EN
    sticky = (rem_q != '0);
`endif
    if (q_q[M+2]) begin
      frac_n = q_q[M+1:2];
      guard  = q_q[1];
      e_n    = e_q;
`ifdef FP_DIV_STICKY_EN
      sticky = (rem_q != '0) | q_q[0];
`endif
    end
`ifdef FP_DIV_STICKY_EN
    round_up = guard & (sticky | frac_n[0]);
`else
    round_up = guard;
`endif
    frac_sum = {1'b0, frac_n} + {{M{1'b0}}, round_up};
    frac_r   = frac_sum[M-1:0];
    e_r      = e_n + {{(EW-1){1'b0}}, frac_sum[M]};
    // e_r is two's complement; its MSB marks a negative exponent.
    ovf      = ~e_r[EW-1] & (e_r >= E_MAX);
    unf      = e_r[EW-1] | (e_r == '0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sign_q          <= 1'b0;
      e_q             <= '0;
      rem_q           <= '0;
      dvsr_q          <= '0;
      q_q             <= '0;
      cnt_q           <= '0;
      fpd_out         <= '0;
      overflow_out    <= 1'b0;
      underflow_out   <= 1'b0;
      div_by_zero_out <= 1'b0;
    end else if (accept) begin
      sign_q <= a_in[W-1] ^ b_in[W-1];
      e_q    <= {2'b00, a_in[W-2:M]} - {2'b00, b_in[W-2:M]} + EW'(BIAS);
      rem_q  <= {1'b0, 1'b1, a_in[M-1:0]};
      dvsr_q <= {1'b1, b_in[M-1:0]};
      q_q    <= '0;
      cnt_q  <= '0;
      if (special) begin
        overflow_out    <= 1'b0;
        underflow_out   <= 1'b0;
        div_by_zero_out <= b_zero;
        if (b_zero) fpd_out <= {a_in[W-1] ^ b_in[W-1], {E{1'b1}}, a_zero, {(M-1){1'b0}}};
        else        fpd_out <= {a_in[W-1] ^ b_in[W-1], {(W-1){1'b0}}};
      end
    end else if (state_q == DIVIDE) begin
      rem_q <= rem_nxt;
      q_q   <= {q_q[M+1:0], q_bit};
      cnt_q <= cnt_q + CW'(1);
    end else if (state_q == NORMALIZE) begin
      overflow_out    <= ovf;
      underflow_out   <= unf & ~ovf;
      div_by_zero_out <= 1'b0;
      if (ovf)      fpd_out <= {sign_q, {E{1'b1}}, {M{1'b0}}};
      else if (unf) fpd_out <= {sign_q, {(W-1){1'b0}}};
      else          fpd_out <= {sign_q, e_r[E-1:0], frac_r};
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed cases, handshake/reset behaviour, chained random operations.
module tb_fp_divider;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy_out, done_out, overflow_out, underflow_out, div_by_zero_out;
  logic [31:0] fpd_out;
  int          n_tests = 0;
  int          n_fail  = 0;

  fp_divider #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .a_in(a), .b_in(b),
    .busy_out(busy_out), .done_out(done_out), .fpd_out(fpd_out),
    .overflow_out(overflow_out), .underflow_out(underflow_out),
    .div_by_zero_out(div_by_zero_out)
  );

  always #5 clk = ~clk;

  // Reference: exact quotient via integer divide, then the rounding and range rules.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [2:0] fl, output int lat);
    logic s;
    longint unsigned ma, mb, num, q, rm;
    int e, frac, g, up;
    bit st;
    s = x[31] ^ y[31];
    if (y[30:0] == 0) begin
      lat = 1; fl = 3'b001;
      r = (x[30:0] == 0) ? {s, 8'hFF, 23'h400000} : {s, 8'hFF, 23'h0};
      return;
    end
    if (x[30:0] == 0) begin
      lat = 1; fl = 3'b000; r = {s, 31'h0};
      return;
    end
    lat = 28; fl = 3'b000;
    ma  = 64'h800000 | 64'(x[22:0]);
    mb  = 64'h800000 | 64'(y[22:0]);
    num = ma << 25;
    q   = num / mb;
    rm  = num % mb;
    e   = int'(x[30:23]) - int'(y[30:23]) + 127;
    if (q >= (64'd1 << 25)) begin
      frac = int'((q >> 2) & 64'h7FFFFF); g = int'((q >> 1) & 1);
      st = (rm != 0) || ((q & 1) != 0);
    end else begin
      frac = int'((q >> 1) & 64'h7FFFFF); g = int'(q & 1);
      st = (rm != 0); e = e - 1;
    end
`ifdef FP_DIV_STICKY_EN
    up = (g != 0 && (st || (frac % 2) == 1)) ? 1 : 0;
`else
    up = g;
`endif
    frac = frac + up;
    if (frac == (1 << 23)) begin frac = 0; e = e + 1; end
    if (e >= 255)    begin r = {s, 8'hFF, 23'h0}; fl = 3'b100; end
    else if (e <= 0) begin r = {s, 31'h0};        fl = 3'b010; end
    else             r = {s, 8'(e), 23'(frac)};
  endfunction

  // Issues one operation (entered and left #1 after a rising edge) and reports what was observed at done.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output logic [31:0] r,
                        output logic [2:0] fl, output int lat, output int busy_bad);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; busy_bad = 0;
    while (!done_out && lat < 60) begin
      if (!busy_out) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done_out) lat = -1;
    if (done_out && busy_out) busy_bad++;
    r  = fpd_out;
    fl = {overflow_out, underflow_out, div_by_zero_out};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
    n_tests++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_out); end
    n_tests++; if (fpd_out !== 32'h0) begin n_fail++; $display("FAIL reset_fpd got=%h exp=0", fpd_out); end
    n_tests++;
    if ({overflow_out, underflow_out, div_by_zero_out} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000", {overflow_out, underflow_out, div_by_zero_out});
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [8] = '{32'h40C00000, 32'h3F800000, 32'hC1000000, 32'h7F000000,
                            32'h00800000, 32'h3F800000, 32'h00000000, 32'h00000000};
    logic [31:0] tb [8] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h3E800000,
                            32'h40000000, 32'h00000000, 32'h00000000, 32'h40A00000};
    logic [31:0] tr [8] = '{32'h40400000, 32'h3EAAAAAB, 32'hC1800000, 32'h7F800000,
                            32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h00000000};
    logic [2:0]  tf [8] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b001, 3'b000};
    int          tl [8] = '{28, 28, 28, 28, 28, 1, 1, 1};
    logic [31:0] r;
    logic [2:0]  fl;
    int          lat, bb;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], r, fl, lat, bb);
      n_tests++; if (r !== tr[i]) begin n_fail++; $display("FAIL dir%0d_fpd got=%h exp=%h", i, r, tr[i]); end
      n_tests++; if (fl !== tf[i]) begin n_fail++; $display("FAIL dir%0d_flags got=%b exp=%b", i, fl, tf[i]); end
      n_tests++; if (lat != tl[i]) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, tl[i]); end
      n_tests++; if (bb != 0) begin n_fail++; $display("FAIL dir%0d_busy bad_cycles=%0d exp=0", i, bb); end
      @(posedge clk); #1;
      n_tests++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done_out); end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, extra_done;
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    while (!done_out && cyc < 60) begin
      if (cyc == 5) begin a = 32'h3F800000; b = 32'h40400000; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_tests++; if (cyc != 28) begin n_fail++; $display("FAIL busy_start_latency got=%0d exp=28", cyc); end
    n_tests++; if (fpd_out !== 32'h40400000) begin n_fail++; $display("FAIL busy_start_fpd got=%h exp=40400000", fpd_out); end
    extra_done = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (done_out) extra_done++;
    end
    n_tests++; if (extra_done != 0) begin n_fail++; $display("FAIL busy_start_extra_done got=%0d exp=0", extra_done); end
    n_tests++; if (fpd_out !== 32'h40400000) begin n_fail++; $display("FAIL busy_start_hold got=%h exp=40400000", fpd_out); end
  endtask

  task automatic test_reset_mid();
    int seen;
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy_out); end
    n_tests++; if (fpd_out !== 32'h0) begin n_fail++; $display("FAIL rst_mid_fpd got=%h exp=0", fpd_out); end
    seen = 0;
    repeat (40) begin
      if (done_out || busy_out) seen++;
      @(posedge clk); #1;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_activity got=%0d exp=0", seen); end
  endtask

  task automatic test_start_in_done();
    logic [31:0] r;
    logic [2:0]  fl;
    int          lat, bb;
    run_op(32'h00000000, 32'h40A00000, r, fl, lat, bb);
    run_op(32'h40C00000, 32'h40000000, r, fl, lat, bb);
    n_tests++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL done_restart1_fpd got=%h exp=40400000", r); end
    n_tests++; if (lat != 28) begin n_fail++; $display("FAIL done_restart1_latency got=%0d exp=28", lat); end
    run_op(32'hC1000000, 32'h3F000000, r, fl, lat, bb);
    n_tests++; if (r !== 32'hC1800000) begin n_fail++; $display("FAIL done_restart2_fpd got=%h exp=C1800000", r); end
    n_tests++; if (lat != 28) begin n_fail++; $display("FAIL done_restart2_latency got=%0d exp=28", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, r, er;
    logic [2:0]  fl, ef;
    int          lat, el, bb, mode;
    for (int i = 0; i < 150; i++) begin
      mode = $urandom_range(0, 9);
      x = $urandom; y = $urandom;
      if (mode >= 4) begin
        x[30:23] = 8'($urandom_range(90, 165));
        y[30:23] = 8'($urandom_range(90, 165));
      end
      if (mode == 0 || mode == 2) x[30:0] = '0;
      if (mode == 1 || mode == 2) y[30:0] = '0;
      model(x, y, er, ef, el);
      run_op(x, y, r, fl, lat, bb);
      n_tests++;
      if (r !== er || fl !== ef || lat != el || bb != 0) begin
        n_fail++;
        $display("FAIL rand%0d a=%h b=%h got fpd=%h flags=%b lat=%0d busy_bad=%0d exp fpd=%h flags=%b lat=%0d",
                 i, x, y, r, fl, lat, bb, er, ef, el);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid();
    test_start_in_done();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
